// File: rtl/turn_sequencer_if.sv
// Turn sequencer bus: groups the player-facing signals of the duel game.
//   btn_a/btn_b   : raw level action buttons of players A and B (6 bits each)
//   hlt_a/hlt_b   : current health of players A and B (0..3)
//   act_a/act_b   : committed action codes sent to the player blocks
//   en_a_n/en_b_n : active-low enables to the player blocks
//   sw            : one-cycle commit strobe per turn
//   round         : committed-turn count
//   game_over     : high once the game is decided
//   winner        : 00 none, 01 A, 10 B, 11 draw (valid while game_over=1)
// master drives buttons/health and observes the turn stream; slave is the sequencer.
interface turn_sequencer_if;
  logic [5:0] btn_a;
  logic [5:0] btn_b;
  logic [1:0] hlt_a;
  logic [1:0] hlt_b;
  logic [2:0] act_a;
  logic [2:0] act_b;
  logic       en_a_n;
  logic       en_b_n;
  logic       sw;
  logic [7:0] round;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output btn_a, btn_b, hlt_a, hlt_b,
    input  act_a, act_b, en_a_n, en_b_n, sw, round, game_over, winner
  );

  modport slave (
    input  btn_a, btn_b, hlt_a, hlt_b,
    output act_a, act_b, en_a_n, en_b_n, sw, round, game_over, winner
  );
endinterface

// File: rtl/turn_sequencer.sv
// turn_sequencer: builds the per-turn action stream for the duel game.
// Each turn it edge-detects both players' buttons, latches the first press of
// each player, then issues a single commit cycle (sw=1, enables low, actions
// valid). The cycle after the commit it samples both healths and either starts
// the next turn or ends the game on KO / round limit.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : turn_sequencer_if.slave (buttons, health in; actions, enables,
//          strobe, round count, game_over, winner out; all outputs registered)
module turn_sequencer #(
  parameter int TURN_CYCLES = 1000,
  parameter int MAX_ROUNDS  = 99
) (
  input  logic clk,
  input  logic rst,
  turn_sequencer_if.slave bus
);

  localparam int TW = $clog2(TURN_CYCLES);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(TURN_CYCLES - 1);
  localparam logic [7:0]    ROUND_LIMIT  = 8'(MAX_ROUNDS);

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_COMMIT  = 2'd1;
  localparam logic [1:0] ST_SETTLE  = 2'd2;
  localparam logic [1:0] ST_OVER    = 2'd3;

  // Lowest-index new press wins; the action code is bit index + 1.
  function automatic logic [2:0] press_code(input logic [5:0] press);
    logic [2:0] code;
    casez (press)
      6'b?????1: code = 3'd1;
      6'b????10: code = 3'd2;
      6'b???100: code = 3'd3;
      6'b??1000: code = 3'd4;
      6'b?10000: code = 3'd5;
      6'b100000: code = 3'd6;
      default:   code = 3'd0;
    endcase
    return code;
  endfunction

  logic [1:0]    state_r;
  logic [TW-1:0] timer_r;
  logic [5:0]    btn_a_prev_r;
  logic [5:0]    btn_b_prev_r;
  logic          lat_a_r;
  logic          lat_b_r;
  logic [2:0]    code_a_r;
  logic [2:0]    code_b_r;
  logic [2:0]    act_a_r;
  logic [2:0]    act_b_r;
  logic          en_a_n_r;
  logic          en_b_n_r;
  logic          sw_r;
  logic [7:0]    round_r;
  logic          game_over_r;
  logic [1:0]    winner_r;

  logic [5:0]    press_a_s;
  logic [5:0]    press_b_s;
  logic [1:0]    state_nx_s;
  logic          lat_a_nx_s;
  logic          lat_b_nx_s;
  logic [2:0]    code_a_nx_s;
  logic [2:0]    code_b_nx_s;
  logic [1:0]    winner_nx_s;

  assign press_a_s = bus.btn_a & ~btn_a_prev_r;
  assign press_b_s = bus.btn_b & ~btn_b_prev_r;

  // Next-state, latch and verdict decisions for the turn FSM.
  always_comb begin
    state_nx_s  = state_r;
    lat_a_nx_s  = lat_a_r;
    lat_b_nx_s  = lat_b_r;
    code_a_nx_s = code_a_r;
    code_b_nx_s = code_b_r;
    winner_nx_s = winner_r;
    case (state_r)
      ST_COLLECT: begin
        if (!lat_a_r && (press_a_s != 6'd0)) begin
          lat_a_nx_s  = 1'b1;
          code_a_nx_s = press_code(press_a_s);
        end else begin
          lat_a_nx_s  = lat_a_r;
        end
        if (!lat_b_r && (press_b_s != 6'd0)) begin
          lat_b_nx_s  = 1'b1;
          code_b_nx_s = press_code(press_b_s);
        end else begin
          lat_b_nx_s  = lat_b_r;
        end
        // A press landing in the timer==0 cycle is already folded into the
        // next-latch values above, so it is committed with this turn.
        if ((lat_a_nx_s && lat_b_nx_s) || (timer_r == TW'(0))) begin
          state_nx_s = ST_COMMIT;
        end else begin
          state_nx_s = ST_COLLECT;
        end
      end
      ST_COMMIT: begin
        state_nx_s = ST_SETTLE;
      end
      ST_SETTLE: begin
        // round_r already holds the count including the turn just committed.
        if ((bus.hlt_a == 2'd0) && (bus.hlt_b == 2'd0)) begin
          winner_nx_s = 2'b11;
          state_nx_s  = ST_OVER;
        end else if (bus.hlt_a == 2'd0) begin
          winner_nx_s = 2'b10;
          state_nx_s  = ST_OVER;
        end else if (bus.hlt_b == 2'd0) begin
          winner_nx_s = 2'b01;
          state_nx_s  = ST_OVER;
        end else if (round_r == ROUND_LIMIT) begin
          if (bus.hlt_a > bus.hlt_b) begin
            winner_nx_s = 2'b01;
          end else if (bus.hlt_b > bus.hlt_a) begin
            winner_nx_s = 2'b10;
          end else begin
            winner_nx_s = 2'b11;
          end
          state_nx_s = ST_OVER;
        end else begin
          lat_a_nx_s  = 1'b0;
          lat_b_nx_s  = 1'b0;
          code_a_nx_s = 3'd0;
          code_b_nx_s = 3'd0;
          state_nx_s  = ST_COLLECT;
        end
      end
      ST_OVER: begin
        state_nx_s = ST_OVER;
      end
      default: begin
        state_nx_s = ST_COLLECT;
      end
    endcase
  end

  // FSM state, press latches and button history.
  always_ff @(posedge clk) begin
    // The button history keeps sampling during reset so that a button held
    // through reset has no rising edge afterwards.
    btn_a_prev_r <= bus.btn_a;
    btn_b_prev_r <= bus.btn_b;
    if (rst) begin
      state_r  <= ST_COLLECT;
      lat_a_r  <= 1'b0;
      lat_b_r  <= 1'b0;
      code_a_r <= 3'd0;
      code_b_r <= 3'd0;
    end else begin
      state_r  <= state_nx_s;
      lat_a_r  <= lat_a_nx_s;
      lat_b_r  <= lat_b_nx_s;
      code_a_r <= code_a_nx_s;
      code_b_r <= code_b_nx_s;
    end
  end

  // Collect-window timer: counts down in COLLECT, reloaded on the way back.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_r <= TIMER_RELOAD;
    end else begin
      case (state_r)
        ST_COLLECT: timer_r <= timer_r - TW'(1);
        ST_SETTLE:  timer_r <= TIMER_RELOAD;
        default:    timer_r <= timer_r;
      endcase
    end
  end

  // Registered turn outputs: commit fields are loaded as COMMIT is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_a_r  <= 3'd0;
      act_b_r  <= 3'd0;
      en_a_n_r <= 1'b1;
      en_b_n_r <= 1'b1;
      sw_r     <= 1'b0;
    end else if (state_nx_s == ST_COMMIT) begin
      act_a_r  <= code_a_nx_s;
      act_b_r  <= code_b_nx_s;
      en_a_n_r <= 1'b0;
      en_b_n_r <= 1'b0;
      sw_r     <= 1'b1;
    end else begin
      act_a_r  <= 3'd0;
      act_b_r  <= 3'd0;
      en_a_n_r <= 1'b1;
      en_b_n_r <= 1'b1;
      sw_r     <= 1'b0;
    end
  end

  // Round counter and game verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_r     <= 8'd0;
      game_over_r <= 1'b0;
      winner_r    <= 2'b00;
    end else begin
      if (state_r == ST_COMMIT) begin
        round_r <= round_r + 8'd1;
      end else begin
        round_r <= round_r;
      end
      game_over_r <= (state_nx_s == ST_OVER);
      winner_r    <= winner_nx_s;
    end
  end

  assign bus.act_a     = act_a_r;
  assign bus.act_b     = act_b_r;
  assign bus.en_a_n    = en_a_n_r;
  assign bus.en_b_n    = en_b_n_r;
  assign bus.sw        = sw_r;
  assign bus.round     = round_r;
  assign bus.game_over = game_over_r;
  assign bus.winner    = winner_r;

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer. Each turn is planned up front
// (press cycle and mask per player, health after the commit) and the expected
// commit cycle, action codes and verdict are computed from the game rules.
module tb_turn_sequencer;

  localparam int T  = 8;
  localparam int MR = 3;
  localparam int NONE = 99;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  turn_sequencer_if bus ();

  turn_sequencer #(.TURN_CYCLES(T), .MAX_ROUNDS(MR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rounds_m = 0;
  int last_sw_cyc = -1;
  int sw_period = 0;
  logic [5:0] hold_a = 6'd0;
  logic [5:0] hold_b = 6'd0;

  // Global time limit so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Rule: lowest set bit wins, code = index + 1.
  function automatic logic [2:0] first_code(input logic [5:0] m);
    for (int i = 0; i < 6; i++) begin
      if (m[i]) return 3'(i + 1);
    end
    return 3'd0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.btn_a = hold_a;
    bus.btn_b = hold_b;
    bus.hlt_a = 2'd3;
    bus.hlt_b = 2'd3;
    step();
    step();
    rst = 1'b0;
    rounds_m = 0;
  endtask

  // Plays one turn from collect cycle 0 through the cycle after SETTLE.
  task automatic play_turn(input int off_a, input logic [5:0] m_a,
                           input int off_b, input logic [5:0] m_b,
                           input logic [1:0] ha, input logic [1:0] hb,
                           input string tag, output bit over);
    bit pa, pb, exp_over;
    int commit_at;
    logic [2:0] ea, eb;
    logic [1:0] ew;
    logic [5:0] junk_a, junk_b, junk_c;
    junk_a = 6'($urandom_range(1, 63));
    junk_b = 6'($urandom_range(1, 63));
    junk_c = 6'($urandom_range(1, 63));
    pa = (off_a < T) && ((m_a & ~hold_a) != 6'd0);
    pb = (off_b < T) && ((m_b & ~hold_b) != 6'd0);
    commit_at = (pa && pb) ? (((off_a > off_b) ? off_a : off_b) + 1) : T;
    ea = pa ? first_code(m_a & ~hold_a) : 3'd0;
    eb = pb ? first_code(m_b & ~hold_b) : 3'd0;
    for (int k = 0; k < commit_at; k++) begin
      checks++;
      if (bus.sw !== 1'b0 || bus.game_over !== 1'b0) begin
        errors++;
        $display("FAIL %s collect k=%0d: sw=%b game_over=%b, required 0 0", tag, k, bus.sw, bus.game_over);
      end
      bus.hlt_a = 2'd3;
      bus.hlt_b = 2'd3;
      bus.btn_a = hold_a | ((k == off_a) ? m_a : ((k == off_a + 2) ? junk_a : 6'd0));
      bus.btn_b = hold_b | ((k == off_b) ? m_b : ((k == off_b + 2) ? junk_b : 6'd0));
      step();
    end
    // Commit cycle; presses here must be ignored.
    checks++;
    if ({bus.sw, bus.en_a_n, bus.en_b_n, bus.act_a, bus.act_b, bus.round} !==
        {1'b1, 1'b0, 1'b0, ea, eb, 8'(rounds_m)}) begin
      errors++;
      $display("FAIL %s commit: sw=%b en=%b%b act_a=%b act_b=%b round=%0d, required 1 00 %b %b %0d",
               tag, bus.sw, bus.en_a_n, bus.en_b_n, bus.act_a, bus.act_b, bus.round, ea, eb, rounds_m);
    end
    if (last_sw_cyc >= 0) sw_period = cyc - last_sw_cyc;
    last_sw_cyc = cyc;
    bus.btn_a = hold_a | junk_c;
    bus.btn_b = hold_b | junk_c;
    bus.hlt_a = ha;
    bus.hlt_b = hb;
    step();
    rounds_m++;
    // Settle cycle.
    checks++;
    if ({bus.sw, bus.en_a_n, bus.en_b_n, bus.act_a, bus.act_b, bus.round} !==
        {1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 8'(rounds_m)}) begin
      errors++;
      $display("FAIL %s settle: sw=%b en=%b%b act_a=%b act_b=%b round=%0d, required 0 11 000 000 %0d",
               tag, bus.sw, bus.en_a_n, bus.en_b_n, bus.act_a, bus.act_b, bus.round, rounds_m);
    end
    bus.btn_a = hold_a;
    bus.btn_b = hold_b;
    exp_over = 1'b1;
    if (ha == 2'd0 && hb == 2'd0)      ew = 2'b11;
    else if (ha == 2'd0)               ew = 2'b10;
    else if (hb == 2'd0)               ew = 2'b01;
    else if (rounds_m == MR)           ew = (ha > hb) ? 2'b01 : ((hb > ha) ? 2'b10 : 2'b11);
    else begin ew = 2'b00; exp_over = 1'b0; end
    step();
    checks++;
    if (bus.game_over !== exp_over || bus.winner !== ew) begin
      errors++;
      $display("FAIL %s verdict: game_over=%b winner=%b, required %b %b", tag, bus.game_over, bus.winner, exp_over, ew);
    end
    over = exp_over;
  endtask

  task automatic test_reset();
    hold_a = 6'd0;
    hold_b = 6'd0;
    do_reset();
    checks++;
    if ({bus.act_a, bus.act_b, bus.en_a_n, bus.en_b_n, bus.sw, bus.round, bus.game_over, bus.winner} !==
        {3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL reset: act=%b/%b en=%b%b sw=%b round=%0d go=%b win=%b, required 000/000 11 0 0 0 00",
               bus.act_a, bus.act_b, bus.en_a_n, bus.en_b_n, bus.sw, bus.round, bus.game_over, bus.winner);
    end
  endtask

  task automatic test_basic();
    bit over;
    do_reset();
    play_turn(0, 6'b000010, 5, 6'b001000, 2'd3, 2'd3, "basic", over);
  endtask

  task automatic test_idle();
    bit over;
    do_reset();
    last_sw_cyc = -1;
    sw_period = 0;
    play_turn(NONE, 6'd0, NONE, 6'd0, 2'd3, 2'd2, "idle1", over);
    play_turn(NONE, 6'd0, NONE, 6'd0, 2'd2, 2'd3, "idle2", over);
    checks++;
    if (sw_period !== T + 2) begin
      errors++;
      $display("FAIL idle_period: sw spacing=%0d, required %0d", sw_period, T + 2);
    end
  endtask

  task automatic test_priority();
    bit over;
    do_reset();
    play_turn(1, 6'b000101, NONE, 6'd0, 2'd3, 2'd3, "prio", over);
    play_turn(2, 6'b110000, 4, 6'b101010, 2'd3, 2'd3, "prio2", over);
  endtask

  task automatic test_held();
    bit over;
    hold_a = 6'b100100;
    hold_b = 6'b000001;
    do_reset();
    play_turn(NONE, 6'd0, 2, 6'b000111, 2'd3, 2'd3, "held", over);
    hold_a = 6'd0;
    hold_b = 6'd0;
  endtask

  task automatic test_ko();
    bit over;
    do_reset();
    play_turn(1, 6'b001000, 3, 6'b000001, 2'd0, 2'd2, "ko_a", over);
    for (int i = 0; i < 15; i++) begin
      bus.btn_a = 6'($urandom);
      bus.btn_b = 6'($urandom);
      step();
      checks++;
      if (bus.sw !== 1'b0 || bus.game_over !== 1'b1 || bus.winner !== 2'b10 || bus.round !== 8'd1) begin
        errors++;
        $display("FAIL over_hold i=%0d: sw=%b go=%b win=%b round=%0d, required 0 1 10 1",
                 i, bus.sw, bus.game_over, bus.winner, bus.round);
      end
    end
    bus.btn_a = 6'd0;
    bus.btn_b = 6'd0;
    do_reset();
    play_turn(0, 6'b010000, 0, 6'b100000, 2'd0, 2'd0, "ko_both", over);
  endtask

  task automatic test_round_limit();
    bit over;
    do_reset();
    play_turn(0, 6'b000001, 1, 6'b000010, 2'd3, 2'd1, "lim1", over);
    play_turn(NONE, 6'd0, 3, 6'b000100, 2'd3, 2'd1, "lim2", over);
    play_turn(6, 6'b001000, 7, 6'b010000, 2'd3, 2'd1, "lim3", over);
    checks++;
    if (over !== 1'b1 || bus.round !== 8'd3) begin
      errors++;
      $display("FAIL round_limit: over=%b round=%0d, required 1 3", over, bus.round);
    end
  endtask

  task automatic test_reset_in_commit();
    do_reset();
    bus.btn_a = 6'b000100;
    bus.btn_b = 6'b000010;
    step();
    checks++;
    if (bus.sw !== 1'b1 || bus.act_a !== 3'd3 || bus.act_b !== 3'd2) begin
      errors++;
      $display("FAIL rc_commit: sw=%b act=%b/%b, required 1 011/010", bus.sw, bus.act_a, bus.act_b);
    end
    rst = 1'b1;
    bus.btn_a = 6'd0;
    bus.btn_b = 6'd0;
    step();
    checks++;
    if ({bus.act_a, bus.act_b, bus.en_a_n, bus.en_b_n, bus.sw, bus.round, bus.game_over, bus.winner} !==
        {3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL rc_reset: act=%b/%b en=%b%b sw=%b round=%0d go=%b win=%b, required reset values",
               bus.act_a, bus.act_b, bus.en_a_n, bus.en_b_n, bus.sw, bus.round, bus.game_over, bus.winner);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    bit over;
    int turns;
    logic [1:0] ha, hb;
    for (int g = 0; g < 8; g++) begin
      do_reset();
      over = 1'b0;
      turns = 0;
      while (!over && turns <= MR) begin
        ha = 2'(($urandom_range(0, 5) > 3) ? 3 : $urandom_range(0, 3));
        hb = 2'(($urandom_range(0, 5) > 3) ? 3 : $urandom_range(0, 3));
        if ($urandom_range(0, 2) != 0) begin
          ha = (ha == 2'd0) ? 2'd1 : ha;
          hb = (hb == 2'd0) ? 2'd2 : hb;
        end
        play_turn($urandom_range(0, T + 2), 6'($urandom_range(1, 63)),
                  $urandom_range(0, T + 2), 6'($urandom_range(1, 63)), ha, hb, "rand", over);
        turns++;
      end
      checks++;
      if (!over) begin
        errors++;
        $display("FAIL rand_end game=%0d: no game_over after %0d turns, required within %0d", g, turns, MR);
      end
    end
  endtask

  initial begin
    bus.btn_a = 6'd0;
    bus.btn_b = 6'd0;
    bus.hlt_a = 2'd3;
    bus.hlt_b = 2'd3;
    test_reset();
    test_basic();
    test_idle();
    test_priority();
    test_held();
    test_ko();
    test_round_limit();
    test_reset_in_commit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
